// File: rtl/seq_mult_param.sv
// seq_mult_param: add-and-shift multiplier, signed (last-step subtract) or unsigned, WIDTH x WIDTH -> 2*WIDTH
module seq_mult_param #(
    parameter int WIDTH      = 8,
    parameter int SIGNED_DEF = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 ClearA_LoadB,
    input  logic                 Mode,
    input  logic [WIDTH-1:0]     Din,
    output logic [WIDTH-1:0]     Aval,
    output logic [WIDTH-1:0]     Bval,
    output logic                 X,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy,
    output logic                 Done
);
    localparam int CW = $clog2(WIDTH) + 1;

    if (WIDTH < 4 || WIDTH > 32 || SIGNED_DEF < 0 || SIGNED_DEF > 1) begin : g_param_check
        $error("seq_mult_param: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a, a_n, b, b_n, m, m_n;
    logic              x, x_n, md, md_n, busy, done;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH:0]    ea, em, sum;

    assign Aval    = a;
    assign Bval    = b;
    assign X       = x;
    assign Product = {a, b};
    assign Busy    = busy;
    assign Done    = done;

    // Datapath registers and registered status flags; status follows the next state so it is valid on entry
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            m     <= '0;
            x     <= 1'b0;
            cnt   <= '0;
            md    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            m     <= m_n;
            x     <= x_n;
            cnt   <= cnt_n;
            md    <= md_n;
            busy  <= (state_n == ADD) || (state_n == SHIFT);
            done  <= (state_n == DONE);
        end
    end

    // Next-state and next-register logic; the final signed step subtracts M to weight the sign bit negatively
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        m_n     = m;
        x_n     = x;
        cnt_n   = cnt;
        md_n    = md;
        ea      = md ? {a[WIDTH-1], a} : {1'b0, a};
        em      = md ? {m[WIDTH-1], m} : {1'b0, m};
        sum     = (md && cnt == CW'(WIDTH-1)) ? ea - em : ea + em;
        case (state)
            IDLE: begin
                if (ClearA_LoadB) begin
                    b_n = Din;
                    a_n = '0;
                    x_n = 1'b0;
                end else if (Run) begin
                    m_n     = Din;
                    md_n    = Mode;
                    a_n     = '0;
                    x_n     = 1'b0;
                    cnt_n   = '0;
                    state_n = ADD;
                end
            end
            ADD: begin
                if (b[0]) begin
                    a_n = sum[WIDTH-1:0];
                    x_n = sum[WIDTH];
                end
                state_n = SHIFT;
            end
            SHIFT: begin
                a_n     = {x, a[WIDTH-1:1]};
                b_n     = {a[0], b[WIDTH-1:1]};
                x_n     = md ? x : 1'b0;
                cnt_n   = cnt + CW'(1);
                state_n = (cnt < CW'(WIDTH-1)) ? ADD : DONE;
            end
            DONE: begin
                if (!Run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Parameter: SIGNED_DEF, default 1, value Mode takes when tied off at integration; documentation only, no effect on RTL behaviour.
REQ-003 Clk  in  1  system clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-005 Run  in  1  level; start request, sampled in IDLE.
REQ-006 ClearA_LoadB  in  1  level; load multiplier, sampled in IDLE.
REQ-007 Mode  in  1  1 = two's-complement signed, 0 = unsigned; sampled with Run.
REQ-008 Din  in  WIDTH  operand input: multiplier on load, multiplicand on start.
REQ-009 Aval  out  WIDTH  accumulator A (product upper half).
REQ-010 Bval  out  WIDTH  register B (multiplier, then product lower half).
REQ-011 X  out  1  extension bit.
REQ-012 Product  out  2*WIDTH  {Aval,Bval}.
REQ-013 Busy  out  1  high in ADD and SHIFT states.
REQ-014 Done  out  1  high in DONE state only.
REQ-015 All outputs SHALL be driven directly from registers.

Function
REQ-016 FSM states: IDLE, ADD, SHIFT, DONE; internal registers: M (WIDTH), iteration counter (clog2(WIDTH)+1 bits), latched mode bit.
REQ-017 IDLE with ClearA_LoadB=1: B<=Din, A<=0, X<=0; remain in IDLE.
REQ-018 IDLE with Run=1 and ClearA_LoadB=0: M<=Din, latch Mode, A<=0, X<=0, counter<=0; next state ADD; B unchanged.
REQ-019 ClearA_LoadB and Run both high in IDLE: load has priority; Run ignored that cycle.
REQ-020 ClearA_LoadB, Run, Mode and Din changes SHALL be ignored in ADD, SHIFT and DONE.
REQ-021 ADD, B[0]=0: A and X unchanged.
REQ-022 ADD, B[0]=1, signed: WIDTH+1-bit sum of sign-extended A and sign-extended M (subtract M instead when counter=WIDTH-1); A<=sum[WIDTH-1:0], X<=sum[WIDTH].
REQ-023 ADD, B[0]=1, unsigned: zero-extended A+M; A<=low WIDTH bits, X<=carry out; never subtract.
REQ-024 ADD always proceeds to SHIFT next cycle.
REQ-025 SHIFT: {A,B} shifts right one bit; A[WIDTH-1]<=X; A[0] moves into B[WIDTH-1]; B[0] discarded.
REQ-026 X after SHIFT: unchanged in signed mode; cleared in unsigned mode.
REQ-027 SHIFT increments counter; next state ADD if counter<WIDTH-1, else DONE.
REQ-028 Latency: the edge accepting Run is edge k; DONE is entered at edge k+2*WIDTH (16 cycles for WIDTH=8); Product is valid and stable from that edge.
REQ-029 DONE: all registers hold; return to IDLE on the first edge sampling Run=0.
REQ-030 Back-to-back use: a new Run after returning to IDLE uses the current B (the previous product lower half) as multiplier.
REQ-031 Arithmetic SHALL be exact for all operand pairs, including the signed most-negative operand.

Reset
REQ-032 Reset=0 SHALL immediately force: state IDLE, A=0, B=0, M=0, X=0, counter=0, latched mode=0, Busy=0, Done=0, Product=0.
REQ-033 Reset asserted mid-operation SHALL abort the operation and discard it; no partial product is retained.
REQ-034 After Reset deasserts, the first edge resumes normal IDLE sampling.

Verification (WIDTH=8)
REQ-035 Load Din=0xFD, then Run with Din=0x07, Mode=1 -> Done at edge k+16; Aval=0xFF, Bval=0xEB, X=1 (-21).
REQ-036 Load 0xFF, then Run with Din=0xFF, Mode=0 -> Product=0xFE01, X=0; Busy high exactly 16 cycles.
REQ-037 Load 0x80, then Run with Din=0x80, Mode=1 -> Product=0x4000, X=0.
REQ-038 Reset pulsed at edge k+7 of an operation -> all outputs 0 and state IDLE immediately; next load and run complete correctly.
REQ-039 Run and ClearA_LoadB high together in IDLE -> B loaded, no operation starts; Run held in DONE keeps Done=1; toggling Din, Mode or ClearA_LoadB while Busy=1 leaves the result unchanged.
REQ-040 Regression repeats REQ-035..REQ-037 at WIDTH=4 and WIDTH=16 with random operands against a reference model; latency is 2*WIDTH.
